// File: rtl/ddr_host_sequencer_pkg.sv
// ddr_host_sequencer_pkg: shared command/state encodings and sizing helpers
package ddr_host_sequencer_pkg;

    localparam int ASIZE_DEF = 23;
    localparam int DSIZE_DEF = 128;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_READA     = 3'd1,
        CMD_WRITEA    = 3'd2,
        CMD_PRECHARGE = 3'd4,
        CMD_LOAD_MODE = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        INIT_PRE,
        INIT_LMR,
        IDLE,
        CMD_WAIT,
        WR_DATA,
        RD_WAIT,
        RD_DATA
    } state_t;

    function automatic int ctr_width(input int burst, input int rd_lat, input int wr_dly);
        return $clog2(burst + rd_lat + wr_dly + 1);
    endfunction

endpackage

// File: rtl/ddr_host_sequencer_beat_timer.sv
// ddr_beat_timer: cycle counter started by CMDACK, flags the data window and beat index
module ddr_beat_timer
    import ddr_host_sequencer_pkg::*;
#(
    parameter int BURST  = 2,
    parameter int RD_LAT = 5,
    parameter int WR_DLY = 2,
    parameter int CW     = ctr_width(BURST, RD_LAT, WR_DLY),
    parameter int BW     = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] first,
    output logic          in_win,
    output logic          last,
    output logic          done,
    output logic [BW-1:0] beat
);
    localparam int XW = CW + 1;

    logic [CW-1:0] cyc;
    logic [XW-1:0] idx;
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;

    // Index of the current cycle relative to CMDACK (0 on the ack cycle itself) and window flags
    always_comb begin
        idx    = load ? '0 : {1'b0, cyc};
        lo     = {1'b0, first};
        hi     = lo + XW'(BURST);
        in_win = idx >= lo && idx < hi;
        last   = idx == hi - XW'(1);
        done   = idx >= hi;
        beat   = BW'(idx - lo);
    end

    // Count cycles since the ack, saturating so a request never wraps the counter
    always_ff @(posedge clk) begin
        if (rst) cyc <= '0;
        else if (load) cyc <= CW'(1);
        else if (cyc != '1) cyc <= cyc + CW'(1);
    end

endmodule

// File: rtl/ddr_host_sequencer.sv
// ddr_host_sequencer: init sequence plus one-at-a-time read/write request sequencing for ddr_sdram
module ddr_host_sequencer
    import ddr_host_sequencer_pkg::*;
#(
    parameter int              ASIZE     = ASIZE_DEF,
    parameter int              DSIZE     = DSIZE_DEF,
    parameter int              BURST     = 2,
    parameter int              WR_DLY    = 2,
    parameter int              RD_LAT    = 5,
    parameter logic [ASIZE-1:0] MODE_WORD = ASIZE'(23'h000022)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ASIZE-1:0]         req_addr,
    input  logic [DSIZE*BURST-1:0]   req_wdata,
    input  logic [DSIZE/8*BURST-1:0] req_wmask,
    output logic                     rsp_valid,
    output logic [DSIZE*BURST-1:0]   rsp_rdata,
    output logic                     init_done,
    output logic [2:0]               CMD,
    output logic [ASIZE-1:0]         ADDR,
    input  logic                     CMDACK,
    output logic [DSIZE-1:0]         DATAIN,
    output logic [DSIZE/8-1:0]       DM,
    input  logic [DSIZE-1:0]         DATAOUT
);
    localparam int MW = DSIZE / 8;
    localparam int CW = ctr_width(BURST, RD_LAT, WR_DLY);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    state_t                 state;
    logic                   wr_q;
    logic [DSIZE*BURST-1:0] wdata_q;
    logic [MW*BURST-1:0]    wmask_q;
    logic                   ack;
    logic                   in_win;
    logic                   last;
    logic                   done;
    logic [BW-1:0]          beat;

    // An acknowledge only counts while a command is actually on the bus
    always_comb ack = CMDACK && CMD != CMD_NOP;

    // Write windows are looked up one cycle early because DATAIN/DM are registered
    ddr_beat_timer #(
        .BURST (BURST),
        .RD_LAT(RD_LAT),
        .WR_DLY(WR_DLY),
        .CW    (CW),
        .BW    (BW)
    ) u_timer (
        .clk   (CLK),
        .rst   (RESET),
        .load  (state == CMD_WAIT && ack),
        .first (wr_q ? CW'(WR_DLY - 1) : CW'(RD_LAT)),
        .in_win(in_win),
        .last  (last),
        .done  (done),
        .beat  (beat)
    );

    // Sequencer FSM with all host and controller outputs registered
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= INIT_PRE;
            CMD       <= CMD_NOP;
            ADDR      <= '0;
            DATAIN    <= '0;
            DM        <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                INIT_PRE: begin
                    if (ack) begin
                        CMD   <= CMD_NOP;
                        state <= INIT_LMR;
                    end else begin
                        CMD  <= CMD_PRECHARGE;
                        ADDR <= '0;
                    end
                end
                INIT_LMR: begin
                    if (ack) begin
                        CMD       <= CMD_NOP;
                        DM        <= '1;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        CMD  <= CMD_LOAD_MODE;
                        ADDR <= MODE_WORD;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        ADDR      <= req_addr;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        DATAIN    <= req_write ? req_wdata[DSIZE-1:0] : DATAIN;
                        CMD       <= req_write ? CMD_WRITEA : CMD_READA;
                        req_ready <= 1'b0;
                        state     <= CMD_WAIT;
                    end
                end
                CMD_WAIT: begin
                    if (ack) begin
                        CMD   <= CMD_NOP;
                        state <= wr_q ? WR_DATA : RD_WAIT;
                        if (wr_q && in_win) begin
                            DATAIN <= wdata_q[beat*DSIZE +: DSIZE];
                            DM     <= wmask_q[beat*MW +: MW];
                        end
                    end
                end
                WR_DATA: begin
                    if (done) begin
                        DATAIN    <= wdata_q[DSIZE-1:0];
                        DM        <= '1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        DATAIN <= in_win ? wdata_q[beat*DSIZE +: DSIZE] : wdata_q[DSIZE-1:0];
                        DM     <= in_win ? wmask_q[beat*MW +: MW] : '1;
                    end
                end
                RD_WAIT, RD_DATA: begin
                    if (in_win) rsp_rdata[beat*DSIZE +: DSIZE] <= DATAOUT;
                    if (last) begin
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (in_win) begin
                        state <= RD_DATA;
                    end
                end
                default: state <= INIT_PRE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_host_sequencer.sv
// tb_ddr_host_sequencer: controller model plus timeline reference model for ddr_host_sequencer
module tb_ddr_host_sequencer;
    localparam int ASIZE  = 23;
    localparam int DSIZE  = 128;
    localparam int BURST  = 2;
    localparam int WR_DLY = 2;
    localparam int RD_LAT = 5;
    localparam int MW     = DSIZE / 8;
    localparam int BIG    = 1 << 30;
    localparam logic [ASIZE-1:0] MODE_WORD = 23'h000022;

    typedef struct {
        bit                     w;
        logic [ASIZE-1:0]       a;
        logic [DSIZE*BURST-1:0] d;
        logic [MW*BURST-1:0]    mk;
    } req_t;

    logic                   CLK = 1'b0;
    logic                   RESET = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_write = 1'b0;
    logic [ASIZE-1:0]       req_addr = '0;
    logic [DSIZE*BURST-1:0] req_wdata = '0;
    logic [MW*BURST-1:0]    req_wmask = '0;
    logic                   rsp_valid;
    logic [DSIZE*BURST-1:0] rsp_rdata;
    logic                   init_done;
    logic [2:0]             CMD;
    logic [ASIZE-1:0]       ADDR;
    logic                   CMDACK = 1'b0;
    logic [DSIZE-1:0]       DATAIN;
    logic [MW-1:0]          DM;
    logic [DSIZE-1:0]       DATAOUT = '0;

    int n_chk = 0;
    int n_err = 0;

    req_t q[$];

    ddr_host_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .CMD      (CMD),
        .ADDR     (ADDR),
        .CMDACK   (CMDACK),
        .DATAIN   (DATAIN),
        .DM       (DM),
        .DATAOUT  (DATAOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DSIZE-1:0] rd_pat(input logic [ASIZE-1:0] a, input int b);
        logic [31:0] w;
        w = {a, 9'(b)};
        return {w ^ 32'h1111_1111, w ^ 32'h2222_2222, w ^ 32'h3333_3333, w};
    endfunction

    // Reference model: controller acks 3 cycles after a command appears and returns
    // rd_pat data RD_LAT cycles after the ack; every output is checked once per cycle.
    int               cyc = 0;
    bit               busy = 0;
    int               rise_cyc = 0;
    logic [2:0]       cmd_e = '0;
    logic [ASIZE-1:0] addr_e = '0;
    req_t             cur;
    int               init_step = 0;
    int               idle_from = BIG;
    int               done_from = BIG;
    bit               prev_rdy = 0;
    bit               wr_act = 0;
    int               wr_ack = 0;
    req_t             wr_r;
    bit               rd_pend = 0;
    int               rd_ack = 0;
    logic [ASIZE-1:0] rd_a = '0;

    initial forever begin
        @(posedge CLK);
        #1;
        cyc++;
        CMDACK = 1'b0;
        if (RESET) begin
            check("rst_cmd", CMD, 0);
            check("rst_addr", ADDR, 0);
            check("rst_datain", DATAIN, 0);
            check("rst_dm", DM, 0);
            check("rst_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_init_done", init_done, 0);
            busy = 0;
            init_step = 0;
            idle_from = BIG;
            done_from = BIG;
            prev_rdy = 0;
            wr_act = 0;
            rd_pend = 0;
            q.delete();
            DATAOUT = {4{$urandom}};
        end else begin
            bit rv_e;
            if (busy) begin
                check("cmd_hold", CMD, cmd_e);
                check("addr_hold", ADDR, addr_e);
            end else if (CMD != 3'd0) begin
                if (init_step < 2) begin
                    cmd_e  = (init_step == 0) ? 3'd4 : 3'd5;
                    addr_e = (init_step == 0) ? '0 : MODE_WORD;
                end else if (q.size() > 0) begin
                    check("cmd_spacing", req_valid && prev_rdy, 1);
                    cur    = q.pop_front();
                    cmd_e  = cur.w ? 3'd2 : 3'd1;
                    addr_e = cur.a;
                end else begin
                    check("cmd_spurious", CMD, 0);
                    cmd_e  = CMD;
                    addr_e = ADDR;
                end
                check("cmd_issue", CMD, cmd_e);
                check("addr_issue", ADDR, addr_e);
                busy = 1;
                rise_cyc = cyc;
            end else if (init_step == 2 && req_valid && prev_rdy && q.size() > 0) begin
                check("cmd_late", CMD, q[0].w ? 3'd2 : 3'd1);
            end
            if (busy && cyc == rise_cyc + 3) begin
                CMDACK = 1'b1;
                busy = 0;
                if (init_step < 2) begin
                    init_step++;
                    if (init_step == 2) begin
                        idle_from = cyc + 1;
                        done_from = cyc + 1;
                    end
                end else if (cmd_e == 3'd2) begin
                    wr_act = 1;
                    wr_ack = cyc;
                    wr_r = cur;
                    idle_from = cyc + WR_DLY + BURST;
                end else begin
                    rd_pend = 1;
                    rd_ack = cyc;
                    rd_a = addr_e;
                    idle_from = cyc + RD_LAT + BURST;
                end
            end
            prev_rdy = init_step == 2 && !busy && cyc >= idle_from;
            check("ready", req_ready, prev_rdy);
            check("init_done", init_done, init_step == 2 && cyc >= done_from);
            if (wr_act && cyc - wr_ack >= WR_DLY && cyc - wr_ack < WR_DLY + BURST) begin
                int k;
                k = cyc - wr_ack - WR_DLY;
                check("wr_data", DATAIN, wr_r.d[k*DSIZE +: DSIZE]);
                check("wr_mask", DM, wr_r.mk[k*MW +: MW]);
            end else if (init_step == 2 && cyc >= done_from) begin
                check("dm_idle", DM, {MW{1'b1}});
            end
            if (wr_act && cyc - wr_ack >= WR_DLY + BURST) wr_act = 0;
            rv_e = rd_pend && cyc == rd_ack + RD_LAT + BURST;
            check("rsp_valid", rsp_valid, rv_e);
            if (rv_e) begin
                logic [DSIZE*BURST-1:0] e;
                for (int b = 0; b < BURST; b++) e[b*DSIZE +: DSIZE] = rd_pat(rd_a, b);
                check("rsp_rdata", rsp_rdata, e);
                rd_pend = 0;
            end
            if (rd_pend && cyc - rd_ack >= RD_LAT && cyc - rd_ack < RD_LAT + BURST)
                DATAOUT = rd_pat(rd_a, cyc - rd_ack - RD_LAT);
            else
                DATAOUT = {4{$urandom}};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic wait_init();
        int i;
        for (i = 0; i < 50 && !(init_done && req_ready); i++) tick(1);
        if (i == 50) check("init_wait", init_done, 1);
    endtask

    task automatic do_req(input bit w, input logic [ASIZE-1:0] a, input logic [DSIZE*BURST-1:0] d,
                          input logic [MW*BURST-1:0] mk);
        req_t r;
        int i;
        r.w = w;
        r.a = a;
        r.d = d;
        r.mk = mk;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = mk;
        req_valid = 1'b1;
        q.push_back(r);
        for (i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check("accept", q.size(), 0);
        q.delete();
        req_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        RESET = 1'b0;
        wait_init();
        do_req(1, 23'h001040, {{16{8'hBB}}, {16{8'hAA}}}, '0);
        tick(1);
        do_req(0, 23'h000200, '0, '0);
        tick(2);
        do_req(1, 23'h0007F0, {{4{$urandom}}, {4{$urandom}}}, 32'hFFFF_0000);
        do_req(0, 23'h000200, '0, '0);
        do_req(0, 23'h000480, '0, '0);
        for (int n = 0; n < 40; n++) begin
            do_req($urandom_range(0, 1), ASIZE'($urandom), {{4{$urandom}}, {4{$urandom}}}, $urandom);
            tick($urandom_range(0, 3));
        end
        tick(20);
        do_req(0, 23'h000333, '0, '0);
        tick(5);
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        wait_init();
        do_req(0, 23'h000200, '0, '0);
        do_req(1, 23'h001040, {{4{$urandom}}, {4{$urandom}}}, 32'h00FF_FF00);
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
